// File: rtl/codec_config_pkg.sv
// Shared types and constants for the WM8731 codec register-write sequencer.
package codec_config_pkg;

   typedef enum logic [3:0] {
      PWRUP_WAIT,
      LOAD,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      CHECK,
      NEXT,
      DONE,
      ERROR
   } seq_state_t;

   // A table entry is {register[6:0], value[8:0]}
   localparam int ENTRY_W = 16;
   localparam int REG_MSB = 15;
   localparam int REG_LSB = 9;
   localparam int VAL_MSB = 8;
   localparam int VAL_LSB = 0;

   localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;
   localparam int         NUM_REGS_DEFAULT = 10;

   localparam logic [ENTRY_W-1:0] WM_RESET      = {7'd15, 9'h000};
   localparam logic [ENTRY_W-1:0] WM_POWER_DOWN = {7'd6,  9'h000};
   localparam logic [ENTRY_W-1:0] WM_LEFT_LIN   = {7'd0,  9'h017};
   localparam logic [ENTRY_W-1:0] WM_RIGHT_LIN  = {7'd1,  9'h017};
   localparam logic [ENTRY_W-1:0] WM_APATH      = {7'd4,  9'h012};
   localparam logic [ENTRY_W-1:0] WM_DPATH      = {7'd5,  9'h000};
   localparam logic [ENTRY_W-1:0] WM_DAIF       = {7'd7,  9'h042};
   localparam logic [ENTRY_W-1:0] WM_SRATE      = {7'd8,  9'h000};
   localparam logic [ENTRY_W-1:0] WM_ACTIVE     = {7'd9,  9'h001};
   localparam logic [ENTRY_W-1:0] WM_LEFT_HP    = {7'd2,  9'h079};

endpackage

// File: rtl/codec_reg_rom.sv
// Combinational lookup of the default WM8731 configuration table.
module codec_reg_rom
   import codec_config_pkg::*;
(
   input  logic [3:0]         index,
   output logic [ENTRY_W-1:0] entry
);

   always_comb begin
      entry = '0;
      case (index)
         4'd0:    entry = WM_RESET;
         4'd1:    entry = WM_POWER_DOWN;
         4'd2:    entry = WM_LEFT_LIN;
         4'd3:    entry = WM_RIGHT_LIN;
         4'd4:    entry = WM_APATH;
         4'd5:    entry = WM_DPATH;
         4'd6:    entry = WM_DAIF;
         4'd7:    entry = WM_SRATE;
         4'd8:    entry = WM_ACTIVE;
         4'd9:    entry = WM_LEFT_HP;
         default: entry = '0;
      endcase
   end

endmodule

// File: rtl/codec_config_seq.sv
// Walks the codec register table after power-up, issuing one 3-byte i2c write
// per entry with NACK retry and a busy-rise timeout; reports done or error.
module codec_config_seq
   import codec_config_pkg::*;
#(
   parameter int         NUM_REGS     = NUM_REGS_DEFAULT,
   parameter logic [7:0] DEV_ADDR     = DEV_ADDR_DEFAULT,
   parameter int         PWRUP_DELAY  = 400,
   parameter int         MAX_RETRY    = 3,
   parameter int         BUSY_TIMEOUT = 1023
)(
   input  logic       clk_400kHz,
   input  logic       rst,
   input  logic       restart,
   output logic       i2c_start,
   output logic [7:0] i2c_address,
   output logic [7:0] i2c_data_0,
   output logic [7:0] i2c_data_1,
   input  logic       i2c_busy,
   input  logic       i2c_nack,
   output logic [3:0] reg_index,
   output logic       done,
   output logic       error
);

   localparam int CNT_W = 16;

   seq_state_t         state, next_state;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         retry;
   logic               busy_q;
   logic               nack_q;
   logic [ENTRY_W-1:0] entry;
   logic               pwrup_last, timeout_hit, busy_rise, last_entry, retry_ok;

   codec_reg_rom u_rom (
      .index (reg_index),
      .entry (entry)
   );

   assign pwrup_last  = (cnt == CNT_W'(PWRUP_DELAY - 1));
   assign timeout_hit = (cnt == CNT_W'(BUSY_TIMEOUT - 1));
   // A busy level left over from a previous transfer must not count as acceptance
   assign busy_rise   = i2c_busy && !busy_q;
   assign last_entry  = (reg_index == 4'(NUM_REGS - 1));
   assign retry_ok    = (retry < 4'(MAX_RETRY));

   always_ff @(posedge clk_400kHz or posedge rst) begin
      if (rst) state <= PWRUP_WAIT;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         PWRUP_WAIT: if (pwrup_last) next_state = LOAD;
         LOAD:       next_state = ISSUE;
         ISSUE:      next_state = WAIT_HI;
         WAIT_HI: begin
            if (busy_rise)        next_state = WAIT_LO;
            else if (timeout_hit) next_state = ERROR;
         end
         WAIT_LO:    if (!i2c_busy) next_state = CHECK;
         CHECK: begin
            if (!nack_q)       next_state = NEXT;
            else if (retry_ok) next_state = ISSUE;
            else               next_state = ERROR;
         end
         NEXT:       next_state = last_entry ? DONE : LOAD;
         DONE,
         ERROR:      if (restart) next_state = PWRUP_WAIT;
         default:    next_state = PWRUP_WAIT;
      endcase
   end

   // The counter keeps running from ISSUE into WAIT_HI so the timeout is measured from the start pulse
   always_ff @(posedge clk_400kHz or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         retry       <= '0;
         busy_q      <= 1'b0;
         nack_q      <= 1'b0;
         i2c_start   <= 1'b0;
         i2c_address <= DEV_ADDR;
         i2c_data_0  <= '0;
         i2c_data_1  <= '0;
         reg_index   <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         busy_q    <= i2c_busy;
         i2c_start <= (next_state == ISSUE);
         done      <= (next_state == DONE);
         error     <= (next_state == ERROR);
         if (next_state != state && next_state != WAIT_HI) cnt <= '0;
         else                                              cnt <= cnt + CNT_W'(1);
         case (state)
            LOAD: begin
               i2c_address <= DEV_ADDR;
               i2c_data_0  <= {entry[REG_MSB:REG_LSB], entry[VAL_MSB]};
               i2c_data_1  <= entry[VAL_MSB-1:VAL_LSB];
            end
            WAIT_LO: if (!i2c_busy) nack_q <= i2c_nack;
            CHECK: begin
               if (!nack_q)       retry <= '0;
               else if (retry_ok) retry <= retry + 4'd1;
            end
            NEXT: if (!last_entry) reg_index <= reg_index + 4'd1;
            DONE,
            ERROR: begin
               if (restart) begin
                  reg_index <= '0;
                  retry     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
